// File: rtl/serial6_pkg.sv
// Shared types and line levels for the 6-bit serial link.
// Pulled in by the transmitter and its bit timer.
package serial6_pkg;

  localparam int DATA_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial6_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and strobes bitEnd on the last cycle.
// Held at zero by clear so every bit period starts from a known count.
module serial6_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic clear,
  output logic bitEnd
);

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt;

  assign bitEnd = (cnt == LAST_CNT);

  // Wrap on bitEnd so the next bit period starts at zero with no extra cycle.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      cnt <= '0;
    end else if (clear || bitEnd) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/serial6_tx.sv
// Parallel-to-serial transmitter for 6-bit words: start, 6 data bits LSB first,
// optional even parity, stop. All outputs are registered from the next state.
module serial6_tx
  import serial6_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] In_data,
  input  logic              In_valid,
  output logic              In_ready,
  output logic              Tx_out,
  output logic              Busy,
  output logic              Done
);

  state_t            state, nextState;
  logic [DATA_W-1:0] shiftReg, nextShift;
  logic [2:0]        bitIdx, nextBitIdx;
  logic              parityBit, nextParity;
  logic              nextTx, nextBusy, nextDone, nextReady;
  logic              bitEnd;
  logic              accept;

  assign accept = In_valid && In_ready;

  serial6_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) bitTimer (
    .Clk   (Clk),
    .Resetn(Resetn),
    .clear (state == IDLE),
    .bitEnd(bitEnd)
  );

  // Next-state logic; the line level is chosen from the state being entered so
  // Tx_out changes on the same edge as the state register.
  always_comb begin
    nextState  = state;
    nextShift  = shiftReg;
    nextBitIdx = bitIdx;
    nextParity = parityBit;
    case (state)
      IDLE: begin
        if (accept) begin
          nextState  = START;
          nextShift  = In_data;
          nextParity = ^In_data;
          nextBitIdx = '0;
        end
      end
      START:  if (bitEnd) nextState = DATA;
      DATA: begin
        if (bitEnd) begin
          nextShift  = shiftReg >> 1;
          nextBitIdx = bitIdx + 3'd1;
          if (bitIdx == 3'(DATA_W - 1)) begin
            nextState = PARITY_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: if (bitEnd) nextState = STOP;
      STOP:   if (bitEnd) nextState = IDLE;
      default: nextState = IDLE;
    endcase

    case (nextState)
      START:   nextTx = START_BIT;
      DATA:    nextTx = nextShift[0];
      PARITY:  nextTx = nextParity;
      STOP:    nextTx = STOP_BIT;
      default: nextTx = IDLE_LEVEL;
    endcase

    nextBusy  = (nextState != IDLE);
    nextReady = (nextState == IDLE);
    nextDone  = (state == STOP) && bitEnd;
  end

  // State and output registers; reset drops any frame in flight and idles the line.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      shiftReg  <= '0;
      bitIdx    <= '0;
      parityBit <= 1'b0;
      Tx_out    <= IDLE_LEVEL;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      In_ready  <= 1'b1;
    end else begin
      state     <= nextState;
      shiftReg  <= nextShift;
      bitIdx    <= nextBitIdx;
      parityBit <= nextParity;
      Tx_out    <= nextTx;
      Busy      <= nextBusy;
      Done      <= nextDone;
      In_ready  <= nextReady;
    end
  end

endmodule

// File: doc/serial6_tx.md
Name: serial6_tx

Overview:
- Parallel-to-serial transmitter for 6-bit words; the sending end of the 6-bit serial link.
- Accepts a word through a valid/ready handshake and frames it as: start bit (0), 6 data bits LSB first, optional even-parity bit, stop bit (1).
- Drives a single-wire line that idles high.
- Sits between the 6-bit datapath blocks and the serial pin/receiver.

Parameters:
CLKS_PER_BIT, 4, clock cycles each serial bit is held; legal range 1..255
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit

Ports:
Clk  input  1  system clock; all state changes on rising edge
Resetn  input  1  asynchronous, active-low reset
In_data  input  6  word to transmit; sampled only on handshake
In_valid  input  1  In_data is valid
In_ready  output  1  registered; high only in IDLE; word accepted on a rising edge where In_valid && In_ready
Tx_out  output  1  serial line, idle high
Busy  output  1  high from the cycle after acceptance until the frame ends
Done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset (Resetn low, asynchronous):
  - Tx_out=1, Busy=0, Done=0, In_ready=1.
  - State IDLE; bit counter, cycle counter and shift register cleared.
  - Applies immediately, including mid-frame. The line returns high with no stop bit, and the partial word is discarded.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Tx_out=1, In_ready=1.
  - On handshake: capture In_data into the shift register, compute parity = XOR of the 6 bits, go to START, drop In_ready, raise Busy.
- Latency: Tx_out goes low on the first edge after the acceptance edge.
- Each state holds Tx_out for exactly CLKS_PER_BIT cycles. The cycle counter runs 0..CLKS_PER_BIT-1, and the state advances when the counter reaches CLKS_PER_BIT-1.
- START: Tx_out=0 → DATA.
- DATA:
  - Tx_out = shift_reg[0]; shift right once per bit.
  - After bit index 5: go to PARITY if PARITY_EN, else STOP.
- PARITY: Tx_out = stored even-parity bit → STOP.
- STOP: Tx_out=1.
  - On the last cycle: next edge → IDLE, Busy=0, Done=1 for exactly one cycle, In_ready=1.
- Frame length: (8 + PARITY_EN) × CLKS_PER_BIT cycles.
- Back-to-back: if In_valid is high in the cycle where In_ready returns high, the word is accepted on that edge. The next start bit follows with zero idle bit-times. Minimum inter-frame gap is 1 clock at idle-high.
- In_data and In_valid changes while not IDLE are ignored. No input affects the frame in flight.
- In_valid held high continuously: one word is accepted per frame, never two.
- CLKS_PER_BIT=1: every state lasts one cycle; the counter is unused but must still behave correctly.

Decomposition:
- Package serial6_pkg:
  - DATA_W=6
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1
- Sub-module serial6_bit_timer:
  - Parameterised cycle counter with clear and a bit_end strobe.
  - The FSM uses it for every bit-period decision.

Test Plan:
- Reset, then In_data=32 (100000), In_valid=1 for one cycle, CLKS_PER_BIT=4, PARITY_EN=1:
  - Tx_out per 4-cycle bit = 0,0,0,0,0,0,1,1,1 (start, d0..d5, parity=1, stop).
  - 36 cycles total, Done pulse once, Busy high for 36 cycles.
- Back-to-back words 32 then 24 (011000), with In_valid held high:
  - Second frame = 0,0,0,0,1,1,0,0,1 (parity 0).
  - Second start bit begins 1 clock after first Done; exactly 2 words accepted.
- Alternate In_data 32/24 every 10 cycles during a frame:
  - Transmitted bits match only the word captured at handshake; In_ready stays low throughout.
- Assert Resetn low mid-DATA of word 24:
  - Tx_out=1, Busy=0, Done=0 immediately (asynchronously).
  - After release, a new word 32 transmits a correct full frame.
- PARITY_EN=0, CLKS_PER_BIT=1, word 63:
  - Tx_out = 0,1,1,1,1,1,1,1 over 8 cycles; Done on the following cycle.
- Idle check:
  - With In_valid=0 for 100 cycles after reset, Tx_out stays 1, In_ready stays 1, and Done never pulses.
